// File: rtl/count_display_driver.sv
// Display stage between the counter and the board pins: a sequential double-dabble
// converts valor to 3-digit BCD, and a scanner multiplexes it onto a 7-segment display.
module count_display_driver #(
  parameter int REFRESH_DIV    = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  valor,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int         CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [3:0] AN_POL   = {4{SEG_ACTIVE_LOW}};
  localparam logic [6:0] SEG_POL  = {7{SEG_ACTIVE_LOW}};

  state_t      state, state_nx;
  logic [7:0]  last_val;
  logic [7:0]  bin_sh;
  logic [11:0] scratch, scratch_adj;
  logic [2:0]  iter;

  logic [CW-1:0] cnt;
  logic [1:0]    dig;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    pat;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // ---------------- converter FSM ----------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (valor != last_val) state_nx = SHIFT;
      SHIFT:   if (iter == 3'd7)      state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign scratch_adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};

  always_ff @(posedge clk) begin
    if (rst) begin
      last_val  <= '0;
      bin_sh    <= '0;
      scratch   <= '0;
      iter      <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (valor != last_val) begin
            bin_sh   <= valor;
            last_val <= valor;
            scratch  <= '0;
            iter     <= '0;
          end
        end
        SHIFT: begin
          // Adjust-then-shift of the 20-bit {scratch, bin_sh} pair.
          scratch <= {scratch_adj[10:0], bin_sh[7]};
          bin_sh  <= {bin_sh[6:0], 1'b0};
          iter    <= iter + 3'd1;
        end
        DONE: begin
          bcd       <= scratch;
          bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- display scanner ----------------
  // Only the committed bcd register is shown, never the in-flight scratch.
  always_comb begin
    nib   = bcd[3:0];
    blank = 1'b0;
    case (dig)
      2'd1: begin
        nib   = bcd[7:4];
        blank = (bcd[11:4] == 8'h00);
      end
      2'd2: begin
        nib   = bcd[11:8];
        blank = (bcd[11:8] == 4'h0);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (nib)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h00;
    endcase
    if (blank) pat = 7'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dig <= 2'd0;
      an  <= 4'b0001 ^ AN_POL;
      seg <= 7'h3F ^ SEG_POL;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        dig <= (dig == 2'd2) ? 2'd0 : dig + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      // an and seg come from the same dig value, so they move together.
      an  <= (4'b0001 << dig) ^ AN_POL;
      seg <= pat ^ SEG_POL;
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver: a scoreboard queue holds expected BCD
// values and a monitor thread compares them on every bcd_valid pulse.
module tb_count_display_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  valor;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  count_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .valor(valor), .bcd(bcd), .bcd_valid(bcd_valid),
    .an(an), .seg(seg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Active-low models: digit d of bcd value b, with leading-zero blanking.
  function automatic logic [6:0] seg_of(input int d, input logic [11:0] b);
    logic [3:0] n;
    logic [6:0] p;
    n = b[d*4 +: 4];
    case (n)
      4'd0: p = 7'h3F; 4'd1: p = 7'h06; 4'd2: p = 7'h5B; 4'd3: p = 7'h4F;
      4'd4: p = 7'h66; 4'd5: p = 7'h6D; 4'd6: p = 7'h7D; 4'd7: p = 7'h07;
      4'd8: p = 7'h7F; 4'd9: p = 7'h6F; default: p = 7'h00;
    endcase
    if ((d == 2 && b[11:8] == 4'h0) || (d == 1 && b[11:4] == 8'h00)) p = 7'h00;
    return ~p;
  endfunction

  function automatic logic [3:0] an_of(input int d);
    return ~(4'b0001 << d);
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({"drain_", tag}, exp_q.size(), 0);
  endtask

  // Checks whatever digit is enabled against the model for value b.
  task automatic scan_check(input string tag, input logic [11:0] b, input int cycles);
    int d;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        default: d = -1;
      endcase
      if (d < 0) check({tag, "_an_onehot"}, an, 4'b1110);
      else       check({tag, "_seg"}, seg, seg_of(d, b));
    end
  endtask

  initial begin
    int n;
    int base;
    rst   = 1'b1;
    valor = 8'd0;

    fork
      forever begin
        @(negedge clk);
        if (bcd_valid === 1'b1) begin
          pulse_cnt++;
          if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
          else                   check("bcd_scoreboard", bcd, exp_q.pop_front());
        end
      end
    join_none

    // Test 1: reset state and idle scan pattern
    repeat (2) @(negedge clk);
    check("rst_bcd", bcd, 12'h000);
    check("rst_valid", bcd_valid, 1'b0);
    check("rst_an", an, 4'b1110);
    check("rst_seg", seg, 7'h40);
    rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      check("scan0_an", an, an_of(((k - 1) / 4) % 3));
      check("scan0_seg", seg, seg_of(((k - 1) / 4) % 3, 12'h000));
    end

    // Test 2: 255, latency and single pulse
    base  = pulse_cnt;
    valor = 8'd255;
    exp_q.push_back(to_bcd(255));
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bcd_valid === 1'b1) break;
    end
    check("latency_255", n, 10);
    repeat (15) @(negedge clk);
    check("pulses_255", pulse_cnt - base, 1);
    check("bcd_255", bcd, 12'h255);
    scan_check("scan255", 12'h255, 24);

    // Test 3: 7 with blanking
    valor = 8'd7;
    exp_q.push_back(to_bcd(7));
    drain("7", 30);
    scan_check("scan7", 12'h007, 24);

    // Test 4: change during conversion is deferred
    valor = 8'd100;
    exp_q.push_back(to_bcd(100));
    repeat (3) @(negedge clk);
    valor = 8'd42;
    exp_q.push_back(to_bcd(42));
    drain("100_42", 40);
    check("bcd_42", bcd, 12'h042);

    // Test 5: reset during SHIFT aborts, then conversion restarts
    base  = pulse_cnt;
    valor = 8'd200;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_bcd", bcd, 12'h000);
    check("midrst_valid", bcd_valid, 1'b0);
    check("midrst_an", an, 4'b1110);
    check("midrst_seg", seg, 7'h40);
    rst = 1'b0;
    exp_q.push_back(to_bcd(200));
    drain("200", 30);
    check("pulses_midrst", pulse_cnt - base, 1);

    // Test 6: full sweep against the golden model
    base = pulse_cnt;
    for (int v = 0; v < 256; v++) begin
      valor = 8'(v);
      exp_q.push_back(to_bcd(v));
      repeat (12) @(negedge clk);
    end
    drain("sweep", 30);
    check("sweep_pulses", pulse_cnt - base, 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
